spi_shift_engine: RTL and testbench

SPI mode-0 master shift engine sitting directly downstream of the bridge's SPI clock divider. It runs on the system clock and treats the divider's output as a data input. It edge-detects that signal to pace an MSB-first full-duplex transfer of one `WIDTH`-bit word, driving `sclk`, `mosi` and `cs_n` and capturing `miso`. It is controlled by the AXI-side register logic through a start/busy/done handshake.

---
 rtl/spi_shift_engine_if.sv | 25 ++
 rtl/spi_shift_engine.sv | 133 +++++++++++++
 tb/tb_spi_shift_engine.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_shift_engine_if.sv
// Control handshake and SPI pin bundle for spi_shift_engine.
// master: the shift engine itself; slave: the register logic / SPI device side.
interface spi_shift_engine_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] tx_data;
   logic [WIDTH-1:0] rx_data;
   logic             busy;
   logic             done;
   logic             sclk;
   logic             mosi;
   logic             miso;
   logic             cs_n;

   modport master (
      input  start, tx_data, miso,
      output rx_data, busy, done, sclk, mosi, cs_n
   );

   modport slave (
      output start, tx_data, miso,
      input  rx_data, busy, done, sclk, mosi, cs_n
   );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 master shift engine paced by edge-detecting the divided spi_clk.
// One WIDTH-bit MSB-first full-duplex transfer per accepted start.
module spi_shift_engine #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clkin,
   input  logic               reset,
   input  logic               spi_clk,
   spi_shift_engine_if.master bus
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic             spi_clk_d;
   logic             rise_c, fall_c;
   logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic [WIDTH-1:0] tx_shift_c;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             cs_n_q, cs_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   assign rise_c     = spi_clk & ~spi_clk_d;
   assign fall_c     = ~spi_clk & spi_clk_d;
   assign tx_shift_c = tx_sr_q << 1;

   // Next-state and next-output logic; everything is registered below.
   always_comb begin
      state_d   = state_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      cnt_d     = cnt_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               tx_sr_d = bus.tx_data;
               cs_n_d  = 1'b0;
               mosi_d  = bus.tx_data[WIDTH-1];
               cnt_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (fall_c) state_d = SHIFT;
         end
         SHIFT: begin
            if (rise_c) begin
               sclk_d  = 1'b1;
               rx_sr_d = WIDTH'({rx_sr_q, bus.miso});
            end else if (fall_c) begin
               sclk_d = 1'b0;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = HOLD;
               end else begin
                  tx_sr_d = tx_shift_c;
                  mosi_d  = tx_shift_c[WIDTH-1];
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end
         HOLD: begin
            if (rise_c) begin
               cs_n_d    = 1'b1;
               mosi_d    = 1'b0;
               rx_data_d = rx_sr_q;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // rx_data is loaded on entry to DONE so it is valid alongside done.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q   <= IDLE;
         spi_clk_d <= 1'b0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         cnt_q     <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         spi_clk_d <= spi_clk;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         cnt_q     <= cnt_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.rx_data = rx_data_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.sclk    = sclk_q;
   assign bus.mosi    = mosi_q;
   assign bus.cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: stimulus pushes expected words,
// a monitor pops and checks them on every done pulse.
module tb_spi_shift_engine;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned HALF    = 5;
   localparam int unsigned MAX_LAT = (2 * WIDTH + 4) * HALF + 3;

   typedef struct {
      logic [WIDTH-1:0] rx;
      bit               lat;
   } exp_t;

   logic clkin = 1'b0;
   logic reset;
   logic spi_clk;
   logic spi_run;
   logic loopback;
   logic miso_val;
   int unsigned div_cnt;
   int unsigned cycle = 0;

   int n_total = 0;
   int n_pass  = 0;
   exp_t exp_q[$];

   spi_shift_engine_if #(.WIDTH(WIDTH)) bus ();

   spi_shift_engine #(.WIDTH(WIDTH)) dut (
      .clkin   (clkin),
      .reset   (reset),
      .spi_clk (spi_clk),
      .bus     (bus.master)
   );

   assign bus.miso = loopback ? bus.mosi : miso_val;

   always #5 clkin = ~clkin;

   always @(posedge clkin) cycle++;

   // Divider model: spi_clk toggles every HALF clkin cycles while running.
   always @(negedge clkin) begin
      if (spi_run) begin
         if (div_cnt == HALF - 1) begin
            div_cnt = 0;
            spi_clk = ~spi_clk;
         end else begin
            div_cnt++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cycle);
   endtask

   // Monitor: per-transfer sclk pulse count, cs_n coverage and done checks.
   int unsigned pulses   = 0;
   bit          cs_bad   = 1'b0;
   bit          sclk_p   = 1'b0;
   bit          busy_p   = 1'b0;
   bit          done_p   = 1'b0;
   int unsigned busy_rise = 0;

   always @(negedge clkin) begin
      exp_t e;
      if (reset) begin
         pulses = 0;
         cs_bad = 1'b0;
      end else begin
         if (bus.sclk && !sclk_p) pulses++;
         if (bus.sclk && bus.cs_n) cs_bad = 1'b1;
         if (bus.busy && !busy_p) busy_rise = cycle;
         if (bus.done) begin
            check("done_one_cycle", 32'(done_p), 32'd0);
            check("done_expected", 32'(exp_q.size() > 0), 32'd1);
            check("busy_with_done", 32'(bus.busy), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("rx_data", 32'(bus.rx_data), 32'(e.rx));
               check("sclk_pulses", pulses, WIDTH);
               check("cs_low_during_sclk", 32'(cs_bad), 32'd0);
               if (e.lat) check("done_latency_ok", 32'((cycle - busy_rise) <= MAX_LAT - 1), 32'd1);
            end
            pulses = 0;
            cs_bad = 1'b0;
         end
      end
      sclk_p = bus.sclk;
      busy_p = bus.busy;
      done_p = bus.done;
   end

   task automatic issue(input logic [WIDTH-1:0] tx, input logic [WIDTH-1:0] rx_exp, input bit lat);
      exp_t e;
      e.rx  = rx_exp;
      e.lat = lat;
      exp_q.push_back(e);
      bus.start   = 1'b1;
      bus.tx_data = tx;
      @(negedge clkin);
      bus.start   = 1'b0;
      bus.tx_data = ~tx;
   endtask

   task automatic wait_done(input string name, input int bound, output bit mosi_any);
      bit seen = 1'b0;
      mosi_any = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clkin);
         if (bus.mosi) mosi_any = 1'b1;
         if (bus.done) seen = 1'b1;
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clkin);
   endtask

   initial begin
      bit          mosi_any;
      bit          stall_bad;
      int unsigned rises;
      int unsigned extra_rises;
      bit          b_prev;
      bit          sp;

      reset       = 1'b1;
      spi_clk     = 1'b0;
      spi_run     = 1'b1;
      div_cnt     = 0;
      loopback    = 1'b1;
      miso_val    = 1'b0;
      bus.start   = 1'b0;
      bus.tx_data = '0;
      idle(3);

      // Reset state
      check("rst_cs_n", 32'(bus.cs_n), 32'd1);
      check("rst_sclk", 32'(bus.sclk), 32'd0);
      check("rst_mosi", 32'(bus.mosi), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_rx_data", 32'(bus.rx_data), 32'd0);
      reset = 1'b0;
      idle(4);

      // Loopback 0xA5
      issue(8'hA5, 8'hA5, 1'b1);
      check("start_busy", 32'(bus.busy), 32'd1);
      check("start_cs_n", 32'(bus.cs_n), 32'd0);
      check("start_mosi_msb", 32'(bus.mosi), 32'd1);
      wait_done("loopback", 300, mosi_any);
      idle(1);
      check("busy_after_done", 32'(bus.busy), 32'd0);
      check("cs_n_after_done", 32'(bus.cs_n), 32'd1);
      idle(3);

      // All ones in, all zeros out
      loopback = 1'b0;
      miso_val = 1'b1;
      issue(8'h00, 8'hFF, 1'b1);
      wait_done("all_ones", 300, mosi_any);
      check("all_ones_mosi_low", 32'(mosi_any), 32'd0);
      check("rx_hold_after_done", 32'(bus.rx_data), 32'hFF);
      idle(4);

      // Start while busy is ignored
      loopback = 1'b1;
      issue(8'h81, 8'h81, 1'b1);
      idle(30);
      bus.start   = 1'b1;
      bus.tx_data = 8'h3C;
      @(negedge clkin);
      bus.start = 1'b0;
      wait_done("start_busy", 300, mosi_any);
      extra_rises = 0;
      b_prev = bus.busy;
      for (int i = 0; i < 150; i++) begin
         @(negedge clkin);
         if (bus.busy && !b_prev) extra_rises++;
         b_prev = bus.busy;
      end
      check("no_second_xfer", extra_rises, 32'd0);
      check("rx_data_held", 32'(bus.rx_data), 32'h81);

      // Reset after the third sclk rise
      issue(8'hC3, 8'hC3, 1'b1);
      rises = 0;
      sp = bus.sclk;
      for (int i = 0; i < 300 && rises < 3; i++) begin
         @(negedge clkin);
         if (bus.sclk && !sp) rises++;
         sp = bus.sclk;
      end
      check("third_rise_seen", rises, 32'd3);
      reset = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clkin);
      reset = 1'b0;
      check("mid_rst_cs_n", 32'(bus.cs_n), 32'd1);
      check("mid_rst_sclk", 32'(bus.sclk), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_rx_data", 32'(bus.rx_data), 32'd0);
      check("mid_rst_done", 32'(bus.done), 32'd0);
      idle(120);
      issue(8'h3C, 8'h3C, 1'b1);
      wait_done("after_rst", 300, mosi_any);
      idle(4);

      // Stalled spi_clk
      spi_run = 1'b0;
      spi_clk = 1'b0;
      div_cnt = 0;
      idle(2);
      issue(8'h96, 8'h96, 1'b0);
      stall_bad = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clkin);
         if (!bus.busy || bus.cs_n || bus.sclk || bus.done) stall_bad = 1'b1;
      end
      check("stall_held", 32'(stall_bad), 32'd0);
      spi_run = 1'b1;
      wait_done("stall_resume", 300, mosi_any);
      idle(4);

      // Back-to-back with start held high
      bus.start   = 1'b1;
      bus.tx_data = 8'h5A;
      exp_q.push_back('{rx: 8'h5A, lat: 1'b1});
      wait_done("b2b_first", 300, mosi_any);
      exp_q.push_back('{rx: 8'h5A, lat: 1'b1});
      @(negedge clkin);
      check("b2b_gap_busy", 32'(bus.busy), 32'd0);
      check("b2b_gap_cs_n", 32'(bus.cs_n), 32'd1);
      @(negedge clkin);
      bus.start = 1'b0;
      check("b2b_second_busy", 32'(bus.busy), 32'd1);
      check("b2b_second_cs_n", 32'(bus.cs_n), 32'd0);
      wait_done("b2b_second", 300, mosi_any);
      idle(150);
      check("b2b_idle_after", 32'(bus.busy), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
